mem_arbiter: RTL

- Shares the single memory port between two requesters: the CPU microcoded controller (MAR/MDR path) and a DMA/IO engine.
- Grants one requester at a time and holds the memory port for a fixed access latency.
- Returns read data and a one-cycle ack to the granted requester.
- Alternates between requesters round-robin when both are requesting.

---
 rtl/mem_arbiter_pkg.sv | 39 +++
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter_wait_counter.sv | 36 +++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the two-requester memory arbiter: FSM state
//   encoding, owner identifiers, wait-counter width and the round-robin
//   pick function.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    ACK    = ST_ACK
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // WAIT_CYC is limited to 0..15, so four bits of countdown suffice.
  localparam int CNT_W = 4;

  // Chooses the next owner. On a tie the requester that did not own the
  // port last time wins; with a single requester that one wins.
  function automatic logic rr_pick(input logic cpu_req,
                                   input logic dma_req,
                                   input logic last_owner);
    logic pick;
    if (cpu_req && dma_req) begin
      pick = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
    end else if (dma_req) begin
      pick = OWN_DMA;
    end else begin
      pick = OWN_CPU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the CPU request port, the DMA request port and the shared
//   memory port of the arbiter.
//   slave  : the arbiter side (takes requests and mem_rdata, drives acks,
//            read data, memory strobes, busy and owner).
//   master : the environment side (requesters plus memory model).
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );

endinterface

// File: rtl/mem_arbiter_wait_counter.sv
// arb_wait_counter
//   Loadable down-counter timing the memory access latency.
//   clk, reset : clock and asynchronous active-low reset
//   load       : load load_val (takes priority over dec)
//   load_val   : value to load
//   dec        : decrement by one, saturating at zero
//   zero       : count is zero
module arb_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Count register: load, decrement or hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between the CPU controller and the DMA engine.
//   One requester is granted at a time; the port is held for WAIT_CYC+1
//   access cycles, followed by a one-cycle ack to the owner. Ties are
//   resolved round-robin, CPU first after reset.
//   clk   : system clock
//   reset : asynchronous active-low reset; an in-flight access is dropped
//   bus   : request ports, memory port, busy and owner (slave modport)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  state_t        state_r;
  state_t        state_nxt_s;

  logic          grant_s;
  logic          grant_owner_s;
  logic          cnt_load_s;
  logic          cnt_dec_s;
  logic          cnt_zero_s;
  logic          capture_s;

  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;

  logic          owner_r;
  logic          last_owner_r;
  logic          we_lat_r;
  logic          mem_en_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;
  logic          cpu_ack_r;
  logic          dma_ack_r;
  logic [DW-1:0] cpu_rdata_r;
  logic [DW-1:0] dma_rdata_r;
  logic          busy_r;

  arb_wait_counter #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_s),
    .load_val (CNT_W'(WAIT_CYC)),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state, grant decision and counter control.
  always_comb begin
    state_nxt_s   = state_r;
    grant_s       = 1'b0;
    grant_owner_s = OWN_CPU;
    cnt_load_s    = 1'b0;
    cnt_dec_s     = 1'b0;
    capture_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          grant_s       = 1'b1;
          grant_owner_s = rr_pick(bus.cpu_req, bus.dma_req, last_owner_r);
          cnt_load_s    = 1'b1;
          state_nxt_s   = ACCESS;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      ACCESS: begin
        if (!cnt_zero_s) begin
          cnt_dec_s   = 1'b1;
        end else begin
          // Read data is valid on the last access cycle only.
          capture_s   = ~we_lat_r;
          state_nxt_s = ACK;
        end
      end
      ACK: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Select the request fields of the requester being granted.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = {AW{1'b0}};
    sel_wdata_s = {DW{1'b0}};
    if (grant_owner_s == OWN_DMA) begin
      sel_we_s    = bus.dma_we;
      sel_addr_s  = bus.dma_addr;
      sel_wdata_s = bus.dma_wdata;
    end else begin
      sel_we_s    = bus.cpu_we;
      sel_addr_s  = bus.cpu_addr;
      sel_wdata_s = bus.cpu_wdata;
    end
  end

  // Grant-time latches: request fields, owner and round-robin history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_r   <= {AW{1'b0}};
      mem_wdata_r  <= {DW{1'b0}};
      we_lat_r     <= 1'b0;
      owner_r      <= OWN_CPU;
      last_owner_r <= OWN_DMA;
    end else if (grant_s) begin
      mem_addr_r   <= sel_addr_s;
      mem_wdata_r  <= sel_wdata_s;
      we_lat_r     <= sel_we_s;
      owner_r      <= grant_owner_s;
      last_owner_r <= grant_owner_s;
    end else begin
      mem_addr_r   <= mem_addr_r;
      mem_wdata_r  <= mem_wdata_r;
      we_lat_r     <= we_lat_r;
      owner_r      <= owner_r;
      last_owner_r <= last_owner_r;
    end
  end

  // Registered strobes, acks and busy, all decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en_r  <= 1'b0;
      mem_we_r  <= 1'b0;
      busy_r    <= 1'b0;
      cpu_ack_r <= 1'b0;
      dma_ack_r <= 1'b0;
    end else begin
      mem_en_r  <= (state_nxt_s == ACCESS);
      mem_we_r  <= (state_nxt_s == ACCESS) && (grant_s ? sel_we_s : we_lat_r);
      busy_r    <= (state_nxt_s != IDLE);
      cpu_ack_r <= (state_nxt_s == ACK) && (owner_r == OWN_CPU);
      dma_ack_r <= (state_nxt_s == ACK) && (owner_r == OWN_DMA);
    end
  end

  // Read-data capture into the owner's register only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata_r <= {DW{1'b0}};
      dma_rdata_r <= {DW{1'b0}};
    end else if (capture_s && (owner_r == OWN_DMA)) begin
      cpu_rdata_r <= cpu_rdata_r;
      dma_rdata_r <= bus.mem_rdata;
    end else if (capture_s) begin
      cpu_rdata_r <= bus.mem_rdata;
      dma_rdata_r <= dma_rdata_r;
    end else begin
      cpu_rdata_r <= cpu_rdata_r;
      dma_rdata_r <= dma_rdata_r;
    end
  end

  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.cpu_ack   = cpu_ack_r;
  assign bus.dma_ack   = dma_ack_r;
  assign bus.cpu_rdata = cpu_rdata_r;
  assign bus.dma_rdata = dma_rdata_r;
  assign bus.busy      = busy_r;
  assign bus.owner     = owner_r;

endmodule
